fetch_stage: RTL

Instruction fetch stage with IF/ID pipeline register, sitting directly upstream of the opcode decoder. It holds the program counter and issues word fetches to instruction memory over a req/ack handshake. It presents the registered instruction, its opcode field and its PC to the decode stage. It absorbs downstream stalls with a one-entry skid buffer, and discards wrong-path fetches on a redirect (branch/jump).

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack fetch to instruction memory, IF/ID register
// with a one-entry skid buffer for decode stalls and wrong-path discard on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        FULL
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_addr, req_addr_n;
    logic        skid_valid, skid_valid_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic        if_valid_n;
    logic [31:0] if_instr_n;
    logic [5:0]  if_opcode_n;
    logic [31:0] if_pc_n;

    logic        accept;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign imem_req  = (state == REQ) || (state == DRAIN);
    assign imem_addr = req_addr;
    assign accept    = !stall || !if_valid;
    assign target    = redirect_pc & ~32'd3;
    assign pc_inc    = pc + 32'd4;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_addr_n   = req_addr;
        skid_valid_n = skid_valid;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        if_valid_n   = if_valid;
        if_instr_n   = if_instr;
        if_pc_n      = if_pc;

        if (redirect) begin
            pc_n         = target;
            if_valid_n   = 1'b0;
            skid_valid_n = 1'b0;
            case (state)
                // An unacked request cannot be withdrawn; let it complete in DRAIN.
                REQ, DRAIN: begin
                    if (imem_ack) begin
                        req_addr_n = target;
                        state_n    = REQ;
                    end else begin
                        state_n = DRAIN;
                    end
                end
                default: begin
                    req_addr_n = target;
                    state_n    = REQ;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    req_addr_n = pc;
                    state_n    = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (accept) begin
                            if_instr_n = imem_rdata;
                            if_pc_n    = req_addr;
                            if_valid_n = 1'b1;
                        end else begin
                            skid_instr_n = imem_rdata;
                            skid_pc_n    = req_addr;
                            skid_valid_n = 1'b1;
                            state_n      = FULL;
                        end
                        pc_n       = pc_inc;
                        req_addr_n = pc_inc;
                    end else if (!stall) begin
                        if_valid_n = 1'b0;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if_valid_n = 1'b0;
                    end
                    if (imem_ack) begin
                        req_addr_n = pc;
                        state_n    = REQ;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        if_instr_n   = skid_instr;
                        if_pc_n      = skid_pc;
                        if_valid_n   = skid_valid;
                        skid_valid_n = 1'b0;
                        state_n      = REQ;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if_opcode_n = if_instr_n[31:26];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_opcode  <= '0;
            if_pc      <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            skid_valid <= skid_valid_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            if_valid   <= if_valid_n;
            if_instr   <= if_instr_n;
            if_opcode  <= if_opcode_n;
            if_pc      <= if_pc_n;
        end
    end

endmodule
